// File: rtl/viterbi_link_ctrl.sv
// Frame controller for a convolutional-code link test. It feeds source bits
// to the encoder, appends zero flush bits, injects channel symbol errors
// (burst or pseudo-random), waits for the decoder latency, and counts both
// injected symbols and decoded-bit mismatches against a delayed copy of the
// source stream.
module viterbi_link_ctrl #(
   parameter int FRAME_LEN = 256,
   parameter int TAIL      = 2,
   parameter int DEC_LAT   = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [1:0]  err_mode_i,
   input  logic [4:0]  err_burst_i,
   input  logic        src_data_i,
   input  logic        dec_data_i,
   output logic        src_req_o,
   output logic        enc_data_o,
   output logic        enc_enable_o,
   output logic [1:0]  err_inj_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] bit_err_cnt_o,
   output logic [15:0] inj_cnt_o
);

   typedef enum logic [2:0] {IDLE, SEND, FLUSH, DRAIN, DONE} state_t;

   localparam logic [15:0] SEND_LAST  = 16'(FRAME_LEN - 1);
   localparam logic [15:0] FLUSH_LAST = 16'((TAIL > 0) ? TAIL - 1 : 0);
   localparam logic [15:0] DRAIN_LAST = 16'(DEC_LAT - 1);
   localparam logic [15:0] LFSR_SEED  = 16'hACE1;

   state_t             state, state_nxt;
   logic [15:0]        phase_ct;
   logic [15:0]        sym_ct;
   logic [15:0]        lfsr;
   logic [1:0]         mode_r;
   logic [4:0]         burst_r;
   logic [DEC_LAT-1:0] dl_vld;
   logic [DEC_LAT-1:0] dl_bit;
   logic               accept;
   logic               inj_hit;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   assign accept = (state == IDLE) && start_i;

   // Next-state decode and the combinational per-state outputs.
   always_comb begin
      state_nxt    = state;
      src_req_o    = 1'b0;
      enc_enable_o = 1'b0;
      enc_data_o   = 1'b0;
      busy_o       = 1'b1;
      done_o       = 1'b0;
      case (state)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) state_nxt = SEND;
         end
         SEND: begin
            src_req_o    = 1'b1;
            enc_enable_o = 1'b1;
            enc_data_o   = src_data_i;
            if (phase_ct == SEND_LAST) state_nxt = (TAIL > 0) ? FLUSH : DRAIN;
         end
         FLUSH: begin
            enc_enable_o = 1'b1;
            if (phase_ct == FLUSH_LAST) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (phase_ct == DRAIN_LAST) state_nxt = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; phase_ct restarts from zero on every state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         phase_ct <= 16'd0;
      end else begin
         state    <= state_nxt;
         phase_ct <= (state_nxt != state) ? 16'd0 : phase_ct + 16'd1;
      end
   end

   // Decide whether the symbol produced this cycle gets corrupted.
   always_comb begin
      inj_hit = 1'b0;
      case (mode_r)
         2'b01:   inj_hit = ({1'b0, sym_ct[4:0]} >= (6'd32 - {1'b0, burst_r}));
         2'b10:   inj_hit = (lfsr[3:0] == 4'd0);
         default: inj_hit = 1'b0;
      endcase
   end

   // Frame context: sampled error config, symbol counter, LFSR, mask and counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_r        <= 2'b00;
         burst_r       <= 5'd0;
         sym_ct        <= 16'd0;
         lfsr          <= LFSR_SEED;
         err_inj_o     <= 2'b00;
         inj_cnt_o     <= 16'd0;
         bit_err_cnt_o <= 16'd0;
      end else begin
         err_inj_o <= (enc_enable_o && inj_hit) ? 2'b10 : 2'b00;
         if (accept) begin
            // Mode 11 is reserved and behaves as a clean channel.
            mode_r        <= (err_mode_i == 2'b11) ? 2'b00 : err_mode_i;
            burst_r       <= err_burst_i;
            sym_ct        <= 16'd0;
            lfsr          <= LFSR_SEED;
            inj_cnt_o     <= 16'd0;
            bit_err_cnt_o <= 16'd0;
         end else begin
            if (enc_enable_o) begin
               sym_ct <= sym_ct + 16'd1;
               lfsr   <= lfsr_step(lfsr);
            end
            if (err_inj_o != 2'b00) inj_cnt_o <= sat_inc(inj_cnt_o);
            if (dl_vld[DEC_LAT-1] && (dl_bit[DEC_LAT-1] != dec_data_i))
               bit_err_cnt_o <= sat_inc(bit_err_cnt_o);
         end
      end
   end

   // Reference delay line aligning each sent data bit with its decoded bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dl_vld <= '0;
         dl_bit <= '0;
      end else begin
         dl_vld[0] <= (state == SEND);
         dl_bit[0] <= (state == SEND) & src_data_i;
         for (int i = 1; i < DEC_LAT; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_bit[i] <= dl_bit[i-1];
         end
      end
   end

endmodule
